// File: rtl/mips_pc_pkg.sv
// Shared next-PC select encoding and default vectors for the MIPS fetch stage.
package mips_pc_pkg;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_ADDR   = 2'b10;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VEC  = 32'h0000_0080;

endpackage

// File: rtl/pc_src_mux.sv
// Four-way next-PC source select, same encoding as the legacy next-PC mux.
module pc_src_mux
    import mips_pc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] seq_pc,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] addr_target,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] src
);

    always_comb begin
        src = seq_pc;
        case (sel)
            PC_SEL_BRANCH: src = branch_target;
            PC_SEL_ADDR:   src = addr_target;
            PC_SEL_JUMP:   src = jump_target;
            default:       src = seq_pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered fetch PC: sequential/branch/jr/jump select, stall hold with a
// latched redirect, and an exception vector that overrides everything but reset.
module pc_sequencer
    import mips_pc_pkg::*;
#(
    parameter int unsigned     WIDTH    = 32,
    parameter int unsigned     INC      = 4,
    parameter int unsigned     ALIGN    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(DEFAULT_EXC_VEC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] addr_target,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             exc_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic             redirect_pend
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = {WIDTH{1'b1}} << ALIGN;

    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] pending_tgt;

    assign pc_next_seq = pc + WIDTH'(INC);

    pc_src_mux #(.WIDTH(WIDTH)) u_src_mux (
        .sel           (sel),
        .seq_pc        (pc_next_seq),
        .branch_target (branch_target),
        .addr_target   (addr_target),
        .jump_target   (jump_target),
        .src           (src)
    );

    // Only redirect targets are aligned; the sequential path is already aligned by construction.
    assign tgt = (sel == PC_SEL_SEQ) ? src : (src & ALIGN_MASK);

    // A redirect seen during a stall is parked and wins over the live sel on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            pending_tgt   <= '0;
            redirect_pend <= 1'b0;
        end else if (exc_req) begin
            pc            <= EXC_VEC;
            redirect_pend <= 1'b0;
        end else if (stall) begin
            if (sel != PC_SEL_SEQ) begin
                pending_tgt   <= tgt;
                redirect_pend <= 1'b1;
            end
        end else if (redirect_pend) begin
            pc            <= pending_tgt;
            redirect_pend <= 1'b0;
        end else begin
            pc <= tgt;
        end
    end

endmodule
